trigger_sequencer: RTL
======================

Name: trigger_sequencer

Overview:
Run/trigger controller that sequences the timestamp timebase and the trigger datapath. It converts software start/stop pulses and the threshold comparator hit into the 2-bit exec state. It also generates the prescaled time tick and the running timestamp. On each accepted trigger it emits one timestamp word over an AXI-Stream-style valid/ready port. It sits between the register interface, the ADC threshold comparator and the event packer.

Parameters:
TIME_STAMP_WIDTH, 16, width of the timestamp counter and stamp output
DIVIDE_NUM, 5, AXIS_ACLK cycles per time tick (>=1; 500 MHz / 100 MHz)
POST_TRG_SAMPLES, 32, AXIS_ACLK cycles spent in TRG after a trigger (>=1)
HOLDOFF_TICKS, 8, time ticks spent in HOLDOFF before re-arming (>=1)

Ports:
AXIS_ACLK  in  1  single clock
AXIS_ARESET  in  1  reset; asynchronous, active-high
RUN_START  in  1  one-cycle pulse: begin run
RUN_STOP  in  1  one-cycle pulse: end run
TRG_IN  in  1  comparator hit (ADC > threshold), level, synchronous
O_EXEC_STATE  out  2  00 INIT, 01 ARMED, 11 TRG, 10 HOLDOFF
O_TIME_TICK  out  1  one-cycle tick at AXIS_ACLK/DIVIDE_NUM
O_CURRENT_TIME  out  TIME_STAMP_WIDTH  running timestamp
O_STAMP_TDATA  out  TIME_STAMP_WIDTH  captured trigger time
O_STAMP_TVALID  out  1  stamp valid
STAMP_TREADY  in  1  downstream accepts stamp
O_OVERRUN  out  1  sticky: trigger lost because a stamp was still pending
O_TRG_COUNT  out  16  accepted triggers this run, saturating

Behaviour:
- Reset (async, while AXIS_ARESET=1): state INIT, O_EXEC_STATE=00, O_TIME_TICK=0, O_CURRENT_TIME=0, O_STAMP_TDATA=0, O_STAMP_TVALID=0, O_OVERRUN=0, O_TRG_COUNT=0, and all internal counters at 0.
- FSM; all transitions take effect on the next AXIS_ACLK edge:
  - INIT->ARMED on RUN_START.
  - ARMED->TRG when TRG_IN=1.
  - TRG->HOLDOFF after exactly POST_TRG_SAMPLES cycles in TRG.
  - HOLDOFF->ARMED after HOLDOFF_TICKS ticks have been counted in HOLDOFF.
  - RUN_STOP forces INIT from any state and has priority over every other event. RUN_START and RUN_STOP together: stop wins.
  - RUN_START outside INIT is ignored.
- Prescaler:
  - Counts 0..DIVIDE_NUM-1 while state != INIT and is held at 0 in INIT.
  - O_TIME_TICK=1 in the cycle the count equals DIVIDE_NUM-1.
  - DIVIDE_NUM=1: tick every cycle outside INIT.
- Timestamp:
  - O_CURRENT_TIME is 0 in INIT and loads 1 on INIT->ARMED.
  - It increments on each tick.
  - Wrap: 2^TIME_STAMP_WIDTH-1 goes to 1; 0 is reserved for "not running".
- Stamp capture on the ARMED->TRG edge:
  - If O_STAMP_TVALID=0, or it is 1 with STAMP_TREADY=1 in the same cycle, then O_STAMP_TDATA takes the O_CURRENT_TIME value sampled in the TRG_IN cycle, O_STAMP_TVALID=1 next cycle, and O_TRG_COUNT increments, saturating at 16'hFFFF.
  - Otherwise the old stamp is kept, O_OVERRUN is set, and the count is not incremented. The FSM still enters TRG.
- Handshake:
  - O_STAMP_TDATA is stable while O_STAMP_TVALID=1.
  - O_STAMP_TVALID clears on the cycle after TVALID and TREADY are both 1, unless a new capture occurs in that same cycle.
- On entry to INIT via RUN_STOP: O_STAMP_TVALID clears and any pending stamp is dropped. O_OVERRUN and O_TRG_COUNT hold their values.
- On RUN_START accepted in INIT: O_OVERRUN and O_TRG_COUNT clear.
- Reset asserted mid-run: all state returns to the reset values immediately (async).
- TRG_IN is ignored in TRG and HOLDOFF, except as described under the optional feature.

Optional Feature:
- Macro: TRG_RETRIGGER_EN.
- Defined: TRG_IN=1 while in TRG, at least one cycle after entry, reloads the post-trigger counter and extends the window. No new stamp is captured and O_TRG_COUNT is not incremented.
- Undefined: TRG_IN is ignored in TRG; the window is fixed at POST_TRG_SAMPLES.

Decomposition:
- Shared package:
  - exec state encodings INIT=2'b00, ARMED=2'b01, TRG=2'b11, HOLDOFF=2'b10; the time counter and packer import these.
  - TIME_STAMP_WIDTH default.
  - reserved timestamp value 0.
- One sub-module: tick_prescaler (DIVIDE_NUM counter, enable in, tick out).

Test Plan:
- Tick and timestamp: reset, then RUN_START at cycle 0 -> O_EXEC_STATE=01 and O_CURRENT_TIME=1 at cycle 1; O_TIME_TICK every 5 cycles; O_CURRENT_TIME=2 after the first tick.
- Single trigger: TRG_IN while O_CURRENT_TIME=7, STAMP_TREADY=1 -> O_STAMP_TDATA=7, TVALID=1 for one cycle, O_TRG_COUNT=1. State is 11 for 32 cycles, then 10 for 8 ticks (40 cycles), then 01.
- Wrap: TIME_STAMP_WIDTH=4, run 15 ticks -> O_CURRENT_TIME goes 15->1 and never shows 0.
- Back-pressure and overrun: STAMP_TREADY=0, two triggers separated by a full TRG+HOLDOFF window -> first stamp held, O_OVERRUN=1, O_TRG_COUNT=1. Raising TREADY consumes the first stamp only.
- Stop priority: RUN_START and RUN_STOP in the same cycle -> state stays 00. RUN_STOP mid-TRG with TVALID=1 -> next cycle state 00, TVALID=0, O_CURRENT_TIME=0. Async reset pulse mid-HOLDOFF -> all outputs return to reset values immediately.
- TRG_RETRIGGER_EN: second TRG_IN 10 cycles into TRG -> TRG lasts 10+32 cycles, one stamp only. Without the macro -> TRG lasts 32 cycles.

Source files
------------

// File: rtl/trigger_sequencer_pkg.sv
// Shared exec-state encodings and timestamp constants for the trigger sequencer,
// the time counter and the event packer.
package trigger_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_HOLDOFF = 2'b10,
    ST_TRG     = 2'b11
  } exec_state_t;

  localparam int TIME_STAMP_WIDTH_DEFAULT = 16;
  // Timestamp value that means "timebase not running"; a live run never shows it.
  localparam int TIME_RESERVED   = 0;
  localparam int TRG_COUNT_WIDTH = 16;

  function automatic logic [TRG_COUNT_WIDTH-1:0] trg_count_inc(
    input logic [TRG_COUNT_WIDTH-1:0] value
  );
    return (&value) ? value : value + TRG_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/trigger_sequencer_tick_prescaler.sv
// Divides AXIS_ACLK by DIVIDE_NUM into a one-cycle time tick while enabled;
// the count is held at zero when disabled or cleared.
module tick_prescaler #(
  parameter int DIVIDE_NUM = 5
) (
  input  logic AXIS_ACLK,
  input  logic AXIS_ARESET,
  input  logic enable,
  input  logic clear,
  output logic time_tick
);

  localparam int CNT_W = (DIVIDE_NUM > 1) ? $clog2(DIVIDE_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVIDE_NUM - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = '0;
    if (enable && !clear && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // With DIVIDE_NUM=1 the count sits at CNT_MAX=0, so every enabled cycle ticks.
  assign time_tick = enable && (count_reg == CNT_MAX);

endmodule

// File: rtl/trigger_sequencer.sv
// Run/trigger controller: exec-state FSM, timebase and trigger timestamp stream.
// Optional macro TRG_RETRIGGER_EN lets TRG_IN extend the post-trigger window.
module trigger_sequencer
  import trigger_sequencer_pkg::*;
#(
  parameter int TIME_STAMP_WIDTH = TIME_STAMP_WIDTH_DEFAULT,
  parameter int DIVIDE_NUM       = 5,
  parameter int POST_TRG_SAMPLES = 32,
  parameter int HOLDOFF_TICKS    = 8
) (
  input  logic                        AXIS_ACLK,
  input  logic                        AXIS_ARESET,
  input  logic                        RUN_START,
  input  logic                        RUN_STOP,
  input  logic                        TRG_IN,
  output logic [1:0]                  O_EXEC_STATE,
  output logic                        O_TIME_TICK,
  output logic [TIME_STAMP_WIDTH-1:0] O_CURRENT_TIME,
  output logic [TIME_STAMP_WIDTH-1:0] O_STAMP_TDATA,
  output logic                        O_STAMP_TVALID,
  input  logic                        STAMP_TREADY,
  output logic                        O_OVERRUN,
  output logic [TRG_COUNT_WIDTH-1:0]  O_TRG_COUNT
);

  localparam int POST_W = $clog2(POST_TRG_SAMPLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_TICKS + 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_TRG_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_TICKS - 1);
  localparam logic [TIME_STAMP_WIDTH-1:0] TIME_MAX   = '1;
  localparam logic [TIME_STAMP_WIDTH-1:0] TIME_FIRST = TIME_STAMP_WIDTH'(TIME_RESERVED + 1);

  exec_state_t                  state_reg, state_next;
  logic [POST_W-1:0]            post_cnt_reg, post_cnt_next;
  logic [HOLD_W-1:0]            hold_cnt_reg, hold_cnt_next;
  logic [TIME_STAMP_WIDTH-1:0]  time_reg, time_next;
  logic [TIME_STAMP_WIDTH-1:0]  tdata_reg, tdata_next;
  logic                         tvalid_reg, tvalid_next;
  logic                         overrun_reg, overrun_next;
  logic [TRG_COUNT_WIDTH-1:0]   trg_count_reg, trg_count_next;

  logic time_tick;
  logic start_accept;
  logic trg_hit;
  logic stamp_free;
  logic retrigger;

  tick_prescaler #(
    .DIVIDE_NUM (DIVIDE_NUM)
  ) u_tick_prescaler (
    .AXIS_ACLK   (AXIS_ACLK),
    .AXIS_ARESET (AXIS_ARESET),
    .enable      (state_reg != ST_INIT),
    .clear       (RUN_STOP),
    .time_tick   (time_tick)
  );

  assign start_accept = (state_reg == ST_INIT) && RUN_START && !RUN_STOP;
  assign trg_hit      = (state_reg == ST_ARMED) && TRG_IN && !RUN_STOP;
  // A pending stamp being accepted this very cycle frees the slot for a new one.
  assign stamp_free   = !tvalid_reg || STAMP_TREADY;

`ifdef TRG_RETRIGGER_EN
  // post_cnt_reg is zero only in the entry cycle, so the initial hit never retriggers.
  assign retrigger = (state_reg == ST_TRG) && TRG_IN && (post_cnt_reg != '0);
`else
  assign retrigger = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    post_cnt_next = post_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    if (RUN_STOP) begin
      state_next    = ST_INIT;
      post_cnt_next = '0;
      hold_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (RUN_START) state_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (TRG_IN) begin
            state_next    = ST_TRG;
            post_cnt_next = '0;
          end
        end
        ST_TRG: begin
          // Reload to 1: the retriggering cycle is the first of the new window.
          if (retrigger) begin
            post_cnt_next = POST_W'(1);
          end else if (post_cnt_reg >= POST_LAST) begin
            state_next    = ST_HOLDOFF;
            post_cnt_next = '0;
            hold_cnt_next = '0;
          end else begin
            post_cnt_next = post_cnt_reg + POST_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (time_tick) begin
            if (hold_cnt_reg == HOLD_LAST) begin
              state_next    = ST_ARMED;
              hold_cnt_next = '0;
            end else begin
              hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            end
          end
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  always_comb begin
    time_next      = time_reg;
    tdata_next     = tdata_reg;
    tvalid_next    = tvalid_reg;
    overrun_next   = overrun_reg;
    trg_count_next = trg_count_reg;
    if (RUN_STOP) begin
      time_next   = '0;
      tvalid_next = 1'b0;
    end else begin
      if (start_accept) begin
        time_next      = TIME_FIRST;
        overrun_next   = 1'b0;
        trg_count_next = '0;
      end else if ((state_reg != ST_INIT) && time_tick) begin
        time_next = (time_reg == TIME_MAX) ? TIME_FIRST : time_reg + TIME_STAMP_WIDTH'(1);
      end
      if (tvalid_reg && STAMP_TREADY) tvalid_next = 1'b0;
      if (trg_hit) begin
        if (stamp_free) begin
          tdata_next     = time_reg;
          tvalid_next    = 1'b1;
          trg_count_next = trg_count_inc(trg_count_reg);
        end else begin
          overrun_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_reg     <= ST_INIT;
      post_cnt_reg  <= '0;
      hold_cnt_reg  <= '0;
      time_reg      <= '0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
      trg_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      post_cnt_reg  <= post_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      time_reg      <= time_next;
      tdata_reg     <= tdata_next;
      tvalid_reg    <= tvalid_next;
      overrun_reg   <= overrun_next;
      trg_count_reg <= trg_count_next;
    end
  end

  assign O_EXEC_STATE   = state_reg;
  assign O_TIME_TICK    = time_tick;
  assign O_CURRENT_TIME = time_reg;
  assign O_STAMP_TDATA  = tdata_reg;
  assign O_STAMP_TVALID = tvalid_reg;
  assign O_OVERRUN      = overrun_reg;
  assign O_TRG_COUNT    = trg_count_reg;

endmodule
